// File: rtl/alu_mdu.sv
// -----------------------------------------------------------------------------
// alu_mdu -- integer ALU with an iterative multiply/divide unit (RV64IM-style).
//
// Single-cycle operations (logic, add/sub, shifts, compares, W forms) and the
// divide special cases (divide-by-zero, signed overflow) complete one cycle
// after acceptance. Multiply and divide iterate one bit per cycle: DATA_WIDTH
// cycles for full-width forms, DATA_WIDTH/2 cycles for W forms. Signed
// operations run on magnitudes and the sign is restored on the final cycle.
//
// Ports
//   clk_i     clock, all state changes on the rising edge
//   rst_i     asynchronous active-high reset
//   valid_i   request valid; accepted when valid_i && ready_o
//   ready_o   high in IDLE only
//   opcode_i  operation select (0..28 legal, 29..31 return 0)
//   A_i, B_i  operands (rs1, rs2/imm)
//   kill_i    synchronous abort; wins over accept and result handoff
//   valid_o   result valid, held until ready_i
//   ready_i   consumer accepts the result
//   C_o       result, forced to 0 while valid_o is low
// -----------------------------------------------------------------------------
module alu_mdu #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [4:0]            opcode_i,
  input  logic [DATA_WIDTH-1:0] A_i,
  input  logic [DATA_WIDTH-1:0] B_i,
  input  logic                  kill_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] C_o
);

  localparam int DW = DATA_WIDTH;
  localparam int H  = DATA_WIDTH / 2;
  localparam int SW = $clog2(DATA_WIDTH);
  localparam logic [SW-1:0] LAST_D = SW'(DW - 1);
  localparam logic [SW-1:0] LAST_W = SW'(H - 1);

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,  OP_SUB    = 5'd1,  OP_OR     = 5'd2,  OP_AND   = 5'd3,
    OP_XOR    = 5'd4,  OP_SLL    = 5'd5,  OP_SRL    = 5'd6,  OP_SRA   = 5'd7,
    OP_SLT    = 5'd8,  OP_SLTU   = 5'd9,  OP_COPY_B = 5'd10, OP_ADDW  = 5'd11,
    OP_SUBW   = 5'd12, OP_SLLW   = 5'd13, OP_SRLW   = 5'd14, OP_SRAW  = 5'd15,
    OP_MUL    = 5'd16, OP_MULH   = 5'd17, OP_MULHSU = 5'd18, OP_MULHU = 5'd19,
    OP_DIV    = 5'd20, OP_DIVU   = 5'd21, OP_REM    = 5'd22, OP_REMU  = 5'd23,
    OP_MULW   = 5'd24, OP_DIVW   = 5'd25, OP_DIVUW  = 5'd26, OP_REMW  = 5'd27,
    OP_REMUW  = 5'd28
  } op_e;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  function automatic logic [DW-1:0] sext_h(input logic [H-1:0] v);
    return {{(DW-H){v[H-1]}}, v};
  endfunction

  state_e state_q, state_d;

  // ---------------------------------------------------------------------------
  // Request decode (only meaningful while a request is being accepted)
  // ---------------------------------------------------------------------------
  logic is_mul, is_div, is_w, sgn_a, sgn_b, want_rem, want_hi;

  // NOTE: every output of an always_comb gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    is_mul   = 1'b0;
    is_div   = 1'b0;
    is_w     = 1'b0;
    sgn_a    = 1'b0;
    sgn_b    = 1'b0;
    want_rem = 1'b0;
    want_hi  = 1'b0;
    case (opcode_i)
      OP_MUL:    is_mul = 1'b1;
      OP_MULH:   begin is_mul = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; want_hi = 1'b1; end
      OP_MULHSU: begin is_mul = 1'b1; sgn_a = 1'b1; want_hi = 1'b1; end
      OP_MULHU:  begin is_mul = 1'b1; want_hi = 1'b1; end
      OP_DIV:    begin is_div = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; end
      OP_DIVU:   is_div = 1'b1;
      OP_REM:    begin is_div = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; want_rem = 1'b1; end
      OP_REMU:   begin is_div = 1'b1; want_rem = 1'b1; end
      // Low half of a product does not depend on operand signedness.
      OP_MULW:   begin is_mul = 1'b1; is_w = 1'b1; end
      OP_DIVW:   begin is_div = 1'b1; is_w = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; end
      OP_DIVUW:  begin is_div = 1'b1; is_w = 1'b1; end
      OP_REMW:   begin is_div = 1'b1; is_w = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; want_rem = 1'b1; end
      OP_REMUW:  begin is_div = 1'b1; is_w = 1'b1; want_rem = 1'b1; end
      default:   ;
    endcase
  end

  // Operands widened to DW (W forms take the low half, sign- or zero-extended),
  // then reduced to magnitudes for the unsigned iterative core.
  logic [DW-1:0] ext_a, ext_b, mag_a, mag_b, min_val;
  logic          neg_a, neg_b;

  assign ext_a = !is_w ? A_i : (sgn_a ? sext_h(A_i[H-1:0]) : {{(DW-H){1'b0}}, A_i[H-1:0]});
  assign ext_b = !is_w ? B_i : (sgn_b ? sext_h(B_i[H-1:0]) : {{(DW-H){1'b0}}, B_i[H-1:0]});
  assign neg_a = sgn_a & ext_a[DW-1];
  assign neg_b = sgn_b & ext_b[DW-1];
  assign mag_a = neg_a ? -ext_a : ext_a;
  assign mag_b = neg_b ? -ext_b : ext_b;

  // Most-negative value of the operating width, already sign-extended.
  assign min_val = is_w ? {{(H+1){1'b1}}, {(H-1){1'b0}}} : {1'b1, {(DW-1){1'b0}}};

  logic          div_zero, div_ovf, multi;
  logic [DW-1:0] dz_res, ovf_res;

  assign div_zero = is_div & (ext_b == '0);
  assign div_ovf  = is_div & sgn_a & (ext_a == min_val) & (&ext_b);
  assign dz_res   = want_rem ? (is_w ? sext_h(A_i[H-1:0]) : A_i) : '1;
  assign ovf_res  = want_rem ? '0 : min_val;
  assign multi    = (is_mul | is_div) & ~div_zero & ~div_ovf;

  // ---------------------------------------------------------------------------
  // Single-cycle ALU
  // ---------------------------------------------------------------------------
  logic [SW-1:0] sh;
  logic [SW-2:0] shw;
  logic [H-1:0]  addw, subw, sllw, srlw, sraw;
  logic [DW-1:0] alu_res, single_res;

  assign sh   = B_i[SW-1:0];
  assign shw  = B_i[SW-2:0];
  assign addw = A_i[H-1:0] + B_i[H-1:0];
  assign subw = A_i[H-1:0] - B_i[H-1:0];
  assign sllw = A_i[H-1:0] << shw;
  assign srlw = A_i[H-1:0] >> shw;
  assign sraw = $signed(A_i[H-1:0]) >>> shw;

  always_comb begin
    alu_res = '0;
    case (opcode_i)
      OP_ADD:    alu_res = A_i + B_i;
      OP_SUB:    alu_res = A_i - B_i;
      OP_OR:     alu_res = A_i | B_i;
      OP_AND:    alu_res = A_i & B_i;
      OP_XOR:    alu_res = A_i ^ B_i;
      OP_SLL:    alu_res = A_i << sh;
      OP_SRL:    alu_res = A_i >> sh;
      OP_SRA:    alu_res = $signed(A_i) >>> sh;
      OP_SLT:    alu_res = {{(DW-1){1'b0}}, $signed(A_i) < $signed(B_i)};
      OP_SLTU:   alu_res = {{(DW-1){1'b0}}, A_i < B_i};
      OP_COPY_B: alu_res = B_i;
      OP_ADDW:   alu_res = sext_h(addw);
      OP_SUBW:   alu_res = sext_h(subw);
      OP_SLLW:   alu_res = sext_h(sllw);
      OP_SRLW:   alu_res = sext_h(srlw);
      OP_SRAW:   alu_res = sext_h(sraw);
      default:   alu_res = '0;
    endcase
  end

  assign single_res = div_zero ? dz_res : (div_ovf ? ovf_res : alu_res);

  // ---------------------------------------------------------------------------
  // Iterative multiply/divide core
  //   multiply: acc += mplier[0] ? mcand : 0; mcand <<= 1; mplier >>= 1
  //   divide:   restoring; acc holds the partial remainder, mcand the divisor,
  //             mplier shifts the dividend out and the quotient in.
  // ---------------------------------------------------------------------------
  logic [2*DW-1:0] acc_q, mcand_q;
  logic [DW-1:0]   mplier_q, result_q;
  logic [SW-1:0]   cnt_q;
  logic            mul_q, is_w_q, want_rem_q, want_hi_q, neg_res_q, neg_a_q;

  logic [2*DW-1:0] mul_acc_n, acc_n, mcand_n, prod;
  logic [DW:0]     rem_sh, rem_n;
  logic            div_ge;
  logic [DW-1:0]   quo_n, mplier_n, quo_s, rem_s, div_pick, fin_res;
  logic            last_iter, accept;

  always_comb begin
    mul_acc_n = acc_q + (mplier_q[0] ? mcand_q : '0);
    rem_sh    = {acc_q[DW-1:0], mplier_q[DW-1]};
    div_ge    = rem_sh >= {1'b0, mcand_q[DW-1:0]};
    rem_n     = div_ge ? rem_sh - {1'b0, mcand_q[DW-1:0]} : rem_sh;
    quo_n     = {mplier_q[DW-2:0], div_ge};

    acc_n     = mul_q ? mul_acc_n : {{(DW-1){1'b0}}, rem_n};
    mcand_n   = mul_q ? mcand_q << 1 : mcand_q;
    mplier_n  = mul_q ? mplier_q >> 1 : quo_n;

    // Result on the final iteration, built from this cycle's step values.
    prod      = neg_res_q ? -mul_acc_n : mul_acc_n;
    quo_s     = neg_res_q ? -quo_n : quo_n;
    rem_s     = neg_a_q ? -rem_n[DW-1:0] : rem_n[DW-1:0];
    div_pick  = want_rem_q ? rem_s : quo_s;
    if (mul_q) begin
      fin_res = is_w_q ? sext_h(prod[H-1:0])
                       : (want_hi_q ? prod[2*DW-1:DW] : prod[DW-1:0]);
    end else begin
      fin_res = is_w_q ? sext_h(div_pick[H-1:0]) : div_pick;
    end
  end

  assign last_iter = (cnt_q == (is_w_q ? LAST_W : LAST_D));
  assign accept    = ready_o & valid_i & ~kill_i;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (valid_i) state_d = multi ? S_BUSY : S_DONE;
      S_BUSY:  if (last_iter) state_d = S_DONE;
      S_DONE:  if (ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (kill_i) state_d = S_IDLE;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: operand and iteration registers are reset as well as the control
  // state, so nothing from an aborted operation survives into the next one.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      result_q   <= '0;
      cnt_q      <= '0;
      mul_q      <= 1'b0;
      is_w_q     <= 1'b0;
      want_rem_q <= 1'b0;
      want_hi_q  <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_a_q    <= 1'b0;
    end else if (accept) begin
      mul_q      <= is_mul;
      is_w_q     <= is_w;
      want_rem_q <= want_rem;
      want_hi_q  <= want_hi;
      neg_res_q  <= neg_a ^ neg_b;
      neg_a_q    <= neg_a;
      cnt_q      <= '0;
      acc_q      <= '0;
      if (multi) begin
        mcand_q  <= {{DW{1'b0}}, is_mul ? mag_a : mag_b};
        // W divides park the dividend in the upper half so that H shifts
        // move all of its bits through the remainder.
        mplier_q <= is_mul ? mag_b : (is_w ? (mag_a << H) : mag_a);
      end else begin
        result_q <= single_res;
      end
    end else if (state_q == S_BUSY && !kill_i) begin
      acc_q    <= acc_n;
      mcand_q  <= mcand_n;
      mplier_q <= mplier_n;
      cnt_q    <= cnt_q + SW'(1);
      if (last_iter) result_q <= fin_res;
    end
  end

  assign ready_o = (state_q == S_IDLE);
  assign valid_o = (state_q == S_DONE);
  assign C_o     = valid_o ? result_q : '0;

endmodule

// File: tb/tb_alu_mdu.sv
// -----------------------------------------------------------------------------
// tb_alu_mdu -- directed scoreboard bench for alu_mdu (DATA_WIDTH = 64).
// The stimulus process pushes the hand-computed result and latency of every
// accepted request; a monitor pops and compares whenever valid_o rises.
// -----------------------------------------------------------------------------
module tb_alu_mdu;

  localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, OR_ = 5'd2, AND_ = 5'd3, XOR_ = 5'd4,
                         SLL = 5'd5, SRL = 5'd6, SRA = 5'd7, SLT = 5'd8, SLTU = 5'd9,
                         COPYB = 5'd10, ADDW = 5'd11, SUBW = 5'd12, SLLW = 5'd13,
                         SRLW = 5'd14, SRAW = 5'd15, MUL = 5'd16, MULH = 5'd17,
                         MULHSU = 5'd18, MULHU = 5'd19, DIV = 5'd20, DIVU = 5'd21,
                         REM = 5'd22, REMU = 5'd23, MULW = 5'd24, DIVW = 5'd25,
                         DIVUW = 5'd26, REMW = 5'd27, REMUW = 5'd28;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINS = 64'h8000_0000_0000_0000;

  logic        clk, rst_i, valid_i, ready_o, kill_i, valid_o, ready_i;
  logic [4:0]  opcode_i;
  logic [63:0] A_i, B_i, C_o;

  alu_mdu #(.DATA_WIDTH(64)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .opcode_i(opcode_i), .A_i(A_i), .B_i(B_i), .kill_i(kill_i),
    .valid_o(valid_o), .ready_i(ready_i), .C_o(C_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] c;
    int          lat;
    string       name;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  // Monitor: compare result and latency on the first cycle of each valid_o.
  bit seen = 1'b0;
  always @(negedge clk) begin
    if (rst_i || !valid_o) begin
      seen = 1'b0;
    end else if (!seen) begin
      exp_t e;
      seen = 1'b1;
      if (sb.size() == 0) begin
        check("unexpected_result", C_o, 64'hX);
      end else begin
        e = sb.pop_front();
        check(e.name, C_o, e.c);
        check({e.name, "_latency"}, 64'(cyc - e.acc_cyc + 1), 64'(e.lat));
      end
    end
  end

  // Present one request and return just after the edge that accepted it.
  task automatic start_op(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                          output bit ok);
    int n = 0;
    @(negedge clk);
    while (!ready_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    ok = ready_o;
    if (!ok) begin
      n_checks++;
      n_err++;
      $display("FAIL ready_timeout: ready_o stayed 0 for %0d cycles", n);
      return;
    end
    valid_i  = 1'b1;
    opcode_i = op;
    A_i      = a;
    B_i      = b;
    @(posedge clk);
    #1;
    valid_i  = 1'b0;
  endtask

  task automatic issue(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp_c, input int lat, input string name);
    bit ok;
    start_op(op, a, b, ok);
    if (ok) sb.push_back('{c: exp_c, lat: lat, name: name, acc_cyc: cyc});
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || !ready_o) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || !ready_o) begin
      n_checks++;
      n_err++;
      $display("FAIL drain_timeout: %0d results outstanding, ready_o=%b", sb.size(), ready_o);
      sb.delete();
    end
  endtask

  // Watch a window in which no result may appear.
  task automatic expect_silence(input string name);
    bit saw = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (valid_o) saw = 1'b1;
    end
    check(name, 64'(saw), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    bit saw_ready;
    rst_i = 1'b1; valid_i = 1'b0; kill_i = 1'b0; ready_i = 1'b1;
    opcode_i = '0; A_i = '0; B_i = '0;

    repeat (2) @(negedge clk);
    check("reset_ready", 64'(ready_o), 64'd1);
    check("reset_valid", 64'(valid_o), 64'd0);
    check("reset_c",     C_o,          64'd0);
    rst_i = 1'b0;

    // Single-cycle ALU operations.
    issue(ADD,   64'd5, 64'd7, 64'd12, 1, "add");
    issue(SUB,   64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1, "sub");
    issue(OR_,   64'hF0F0, 64'h0FF0, 64'hFFF0, 1, "or");
    issue(AND_,  64'hF0F0, 64'h0FF0, 64'h00F0, 1, "and");
    issue(XOR_,  64'hF0F0, 64'h0FF0, 64'hFF00, 1, "xor");
    issue(SLL,   64'd1, 64'h41, 64'd2, 1, "sll_mask");
    issue(SRL,   MINS, 64'd63, 64'd1, 1, "srl63");
    issue(SRA,   MINS, 64'd4, 64'hF800_0000_0000_0000, 1, "sra");
    issue(SLT,   ONES, 64'd1, 64'd1, 1, "slt");
    issue(SLTU,  ONES, 64'd1, 64'd0, 1, "sltu");
    issue(COPYB, 64'hDEAD, 64'h1234, 64'h1234, 1, "copy_b");
    issue(ADDW,  64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000, 1, "addw_ovf");
    issue(SUBW,  64'h1_0000_0000, 64'd1, ONES, 1, "subw");
    issue(SLLW,  64'h4000_0000, 64'h21, 64'hFFFF_FFFF_8000_0000, 1, "sllw_mask");
    issue(SRLW,  64'hFFFF_FFFF_8000_0000, 64'd31, 64'd1, 1, "srlw");
    issue(SRAW,  64'h8000_0000, 64'd4, 64'hFFFF_FFFF_F800_0000, 1, "sraw");
    issue(5'd29, 64'd5, 64'd7, 64'd0, 1, "illegal29");
    issue(5'd31, ONES, ONES, 64'd0, 1, "illegal31");

    // Iterative multiply.
    issue(MUL,    64'd3, ONES - 64'd1, 64'hFFFF_FFFF_FFFF_FFFA, 65, "mul");
    issue(MULHU,  ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 65, "mulhu_max");
    saw_ready = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (valid_o) break;
      if (ready_o) saw_ready = 1'b1;
    end
    check("mulhu_ready_low", 64'(saw_ready), 64'd0);
    issue(MULH,   MINS, 64'd2, ONES, 65, "mulh");
    issue(MULHSU, ONES, 64'd2, ONES, 65, "mulhsu");
    issue(MULHU,  ONES, 64'd2, 64'd1, 65, "mulhu");
    issue(MULW,   64'hDEAD_0000_4000_0000, 64'd2, 64'hFFFF_FFFF_8000_0000, 33, "mulw");

    // Iterative divide, including sign handling and W forms.
    issue(DIV,   ONES - 64'd6, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, "div_neg");
    issue(REM,   ONES - 64'd6, 64'd2, ONES, 65, "rem_neg");
    issue(DIV,   64'd7, ONES - 64'd1, 64'hFFFF_FFFF_FFFF_FFFD, 65, "div_negdiv");
    issue(REM,   64'd7, ONES - 64'd1, 64'd1, 65, "rem_negdiv");
    issue(DIVU,  64'd100, 64'd7, 64'd14, 65, "divu");
    issue(REMU,  64'd100, 64'd7, 64'd2, 65, "remu");
    issue(DIVW,  ONES - 64'd6, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33, "divw");
    issue(REMW,  ONES - 64'd6, 64'd2, ONES, 33, "remw");
    issue(DIVUW, 64'hFFFF_FFFF, 64'd2, 64'h7FFF_FFFF, 33, "divuw");
    issue(REMW,  64'h1_0000_0005, 64'd3, 64'd2, 33, "remw_upper");

    // Divide special cases complete in one cycle.
    issue(DIV,   MINS, ONES, MINS, 1, "div_ovf");
    issue(REM,   MINS, ONES, 64'd0, 1, "rem_ovf");
    issue(DIVU,  64'd7, 64'd0, ONES, 1, "divu_zero");
    issue(REMU,  64'd7, 64'd0, 64'd7, 1, "remu_zero");
    issue(DIV,   64'd5, 64'd0, ONES, 1, "div_zero");
    issue(REMUW, 64'h8000_0000, 64'h1_0000_0000, 64'hFFFF_FFFF_8000_0000, 1, "remuw_zero");
    issue(DIVW,  64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, "divw_ovf");
    wait_idle();

    // Result held while the consumer stalls.
    ready_i = 1'b0;
    issue(SRA, 64'hF000_0000_0000_0000, 64'd4, 64'hFF00_0000_0000_0000, 1, "sra_hold");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", 64'(valid_o), 64'd1);
      check("hold_c",     C_o,          64'hFF00_0000_0000_0000);
      check("hold_ready", 64'(ready_o), 64'd0);
    end
    ready_i = 1'b1;
    @(negedge clk);
    check("handoff_valid", 64'(valid_o), 64'd0);
    check("handoff_ready", 64'(ready_o), 64'd1);
    wait_idle();

    // Kill in the tenth busy cycle of a divide.
    start_op(DIVU, 64'd100, 64'd7, ok);
    repeat (9) @(posedge clk);
    @(negedge clk);
    kill_i = 1'b1;
    @(negedge clk);
    kill_i = 1'b0;
    check("kill_ready", 64'(ready_o), 64'd1);
    check("kill_valid", 64'(valid_o), 64'd0);
    check("kill_c",     C_o,          64'd0);
    expect_silence("kill_no_result");

    // Reset in the middle of a multiply.
    start_op(MUL, 64'd3, 64'd5, ok);
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b1;
    #1;
    check("rst_ready", 64'(ready_o), 64'd1);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_c",     C_o,          64'd0);
    @(negedge clk);
    rst_i = 1'b0;
    expect_silence("rst_no_result");

    issue(ADD, 64'd2, 64'd3, 64'd5, 1, "add_after_abort");
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end

endmodule
